// File: rtl/lsu_mem_req_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_req_pkg
// Purpose  : Shared load/store decode items for the LSU memory requester:
//            RV32I load/store func3 encodings, LSU FSM state encoding and
//            helpers for access size masks and func3 legality.
// Revision : 1.0 - initial release
// ============================================================================
package lsu_mem_req_pkg;

  // RV32I load func3 encodings
  typedef enum logic [2:0] {
    LD_LB  = 3'b000,
    LD_LH  = 3'b001,
    LD_LW  = 3'b010,
    LD_LBU = 3'b100,
    LD_LHU = 3'b101
  } ld_func3_e;

  // RV32I store func3 encodings
  typedef enum logic [2:0] {
    ST_SB = 3'b000,
    ST_SH = 3'b001,
    ST_SW = 3'b010
  } st_func3_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ0  = 3'd1,
    S_WAIT0 = 3'd2,
    S_REQ1  = 3'd3,
    S_WAIT1 = 3'd4,
    S_RESP  = 3'd5
  } lsu_state_e;

  // Byte-lane mask for an aligned access of the size in func3[1:0].
  function automatic logic [3:0] size_mask(input logic [1:0] size);
    logic [3:0] mask;
    case (size)
      2'b00:   mask = 4'b0001;
      2'b01:   mask = 4'b0011;
      2'b10:   mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

  function automatic logic func3_legal(input logic is_store, input logic [2:0] f3);
    logic legal;
    case (f3)
      ST_SB, ST_SH, ST_SW: legal = 1'b1;
      LD_LBU, LD_LHU:      legal = ~is_store;
      default:             legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_align
// Purpose  : Combinational lane logic for the LSU: byte-enable generation for
//            up to two word accesses, store-data lane positioning, and load
//            word merge with sign/zero extension.
// Ports    : off_i     byte offset within the first word
//            func3_i   RV32I load/store func3
//            wdata_i   store data, low-aligned
//            word0_i   first read word,  word1_i second read word (0 if none)
//            be0_o/be1_o       byte enables of access 0/1
//            split_o           a second access is needed
//            wdata0_o/wdata1_o lane-positioned write data of access 0/1
//            rdata_o           merged and extended load data
// Revision : 1.0 - initial release
// ============================================================================
module lsu_align
  import lsu_mem_req_pkg::*;
(
  input  logic [1:0]  off_i,
  input  logic [2:0]  func3_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] word0_i,
  input  logic [31:0] word1_i,
  output logic [3:0]  be0_o,
  output logic [3:0]  be1_o,
  output logic        split_o,
  output logic [31:0] wdata0_o,
  output logic [31:0] wdata1_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  ext_be;
  logic [63:0] ext_wdata;
  logic [31:0] raw;

  // Enables over a two-word window; anything in the upper nibble spills
  // into the next word.
  assign ext_be    = {4'b0000, size_mask(func3_i[1:0])} << off_i;
  assign be0_o     = ext_be[3:0];
  assign be1_o     = ext_be[7:4];
  assign split_o   = |ext_be[7:4];

  assign ext_wdata = {32'b0, wdata_i} << {off_i, 3'b000};
  assign wdata0_o  = ext_wdata[31:0];
  assign wdata1_o  = ext_wdata[63:32];

  assign raw = 32'({word1_i, word0_i} >> {off_i, 3'b000});

  always_comb begin
    rdata_o = raw;
    case (func3_i)
      LD_LB:   rdata_o = {{24{raw[7]}}, raw[7:0]};
      LD_LH:   rdata_o = {{16{raw[15]}}, raw[15:0]};
      LD_LBU:  rdata_o = {24'b0, raw[7:0]};
      LD_LHU:  rdata_o = {16'b0, raw[15:0]};
      default: rdata_o = raw;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_req.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_req
// Purpose  : Pipeline-side load/store initiator. Accepts one RV32I load or
//            store, issues one or two word-aligned byte-enabled accesses over
//            a req/gnt/rvalid interface, merges/extends load data and stalls
//            the pipeline until the single-cycle response.
// Ports    : clk, rst_n (async, active-low)
//            req_*_i / req_ready_o   pipeline request handshake
//            rsp_valid_o, rsp_rdata_o, rsp_err_o, stall_o  completion side
//            mem_*_o / mem_*_i       memory request and response
// Revision : 1.0 - initial release
// ============================================================================
module lsu_mem_req
  import lsu_mem_req_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_is_store_i,
  input  logic [2:0]        req_func3_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  generate
    if (DATA_W != 32) begin : g_data_w_check
      $error("lsu_mem_req: DATA_W must be 32");
    end
  endgenerate

  lsu_state_e        state_q;
  logic              ready_q;
  logic              busy_q;
  logic              is_store_q;
  logic [2:0]        func3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       word0_q;

  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [3:0]        mem_be_q;
  logic [31:0]       mem_wdata_q;
  logic              rsp_valid_q;
  logic [31:0]       rsp_rdata_q;
  logic              rsp_err_q;

  logic              accept;
  logic              legal;
  logic              cur_is_store;
  logic [2:0]        cur_func3;
  logic [ADDR_W-1:0] cur_addr;
  logic [31:0]       cur_wdata;
  logic [ADDR_W-1:0] base0;
  logic [ADDR_W-1:0] base1;
  logic [31:0]       ld_word0;
  logic [31:0]       ld_word1;
  logic [3:0]        al_be0;
  logic [3:0]        al_be1;
  logic              al_split;
  logic [31:0]       al_wdata0;
  logic [31:0]       al_wdata1;
  logic [31:0]       al_rdata;

  assign accept = req_valid_i & ready_q;

  // In IDLE the lane logic looks at the live request so access 0 can be
  // registered on the accepting edge; afterwards it uses the latched copy.
  assign cur_is_store = ready_q ? req_is_store_i : is_store_q;
  assign cur_func3    = ready_q ? req_func3_i    : func3_q;
  assign cur_addr     = ready_q ? req_addr_i     : addr_q;
  assign cur_wdata    = ready_q ? req_wdata_i    : wdata_q;

  assign legal = func3_legal(cur_is_store, cur_func3);
  assign base0 = {cur_addr[ADDR_W-1:2], 2'b00};
  assign base1 = base0 + ADDR_W'(4);

  // The word arriving this cycle is merged directly, so the response can be
  // registered on the same edge that sees the final rvalid.
  assign ld_word0 = (state_q == S_WAIT0) ? mem_rdata_i : word0_q;
  assign ld_word1 = (state_q == S_WAIT1) ? mem_rdata_i : 32'b0;

  lsu_align u_align (
    .off_i    (cur_addr[1:0]),
    .func3_i  (cur_func3),
    .wdata_i  (cur_wdata),
    .word0_i  (ld_word0),
    .word1_i  (ld_word1),
    .be0_o    (al_be0),
    .be1_o    (al_be1),
    .split_o  (al_split),
    .wdata0_o (al_wdata0),
    .wdata1_o (al_wdata1),
    .rdata_o  (al_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      is_store_q  <= 1'b0;
      func3_q     <= 3'b000;
      addr_q      <= '0;
      wdata_q     <= '0;
      word0_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            is_store_q <= req_is_store_i;
            func3_q    <= req_func3_i;
            addr_q     <= req_addr_i;
            wdata_q    <= req_wdata_i;
            ready_q    <= 1'b0;
            if (legal) begin
              state_q     <= S_REQ0;
              busy_q      <= 1'b1;
              mem_req_q   <= 1'b1;
              mem_we_q    <= req_is_store_i;
              mem_addr_q  <= base0;
              mem_be_q    <= al_be0;
              mem_wdata_q <= req_is_store_i ? al_wdata0 : 32'b0;
            end else begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end
          end
        end
        S_REQ0, S_REQ1: begin
          if (mem_gnt_i) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= '0;
            if (!is_store_q) begin
              state_q <= (state_q == S_REQ0) ? S_WAIT0 : S_WAIT1;
            end else if ((state_q == S_REQ0) && al_split) begin
              state_q     <= S_REQ1;
              mem_req_q   <= 1'b1;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= base1;
              mem_be_q    <= al_be1;
              mem_wdata_q <= al_wdata1;
            end else begin
              state_q     <= S_RESP;
              busy_q      <= 1'b0;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= '0;
            end
          end
        end
        S_WAIT0: begin
          if (mem_rvalid_i) begin
            word0_q <= mem_rdata_i;
            if (al_split) begin
              state_q     <= S_REQ1;
              mem_req_q   <= 1'b1;
              mem_we_q    <= 1'b0;
              mem_addr_q  <= base1;
              mem_be_q    <= al_be1;
              mem_wdata_q <= '0;
            end else begin
              state_q     <= S_RESP;
              busy_q      <= 1'b0;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= al_rdata;
            end
          end
        end
        S_WAIT1: begin
          if (mem_rvalid_i) begin
            state_q     <= S_RESP;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= al_rdata;
          end
        end
        S_RESP: begin
          state_q     <= S_IDLE;
          ready_q     <= 1'b1;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= '0;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o = ready_q;
  assign stall_o     = busy_q | accept;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_be_o    = mem_be_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_req.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_mem_req
// Purpose  : Self-checking bench for lsu_mem_req: directed scenarios plus
//            randomized loads/stores against a byte-addressed memory model
//            with a randomly delayed grant/rvalid responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_req;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_is_store;
  logic [2:0]  req_func3;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, rsp_valid, rsp_err, stall;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  logic        auto_mode;
  logic        a_gnt, a_rvalid, m_gnt, m_rvalid;
  logic [31:0] a_rdata, m_rdata;

  assign mem_gnt    = auto_mode ? a_gnt    : m_gnt;
  assign mem_rvalid = auto_mode ? a_rvalid : m_rvalid;
  assign mem_rdata  = auto_mode ? a_rdata  : m_rdata;

  always #5 clk = ~clk;

  lsu_mem_req #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_is_store_i(req_is_store), .req_func3_i(req_func3),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .stall_o(stall),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_be_o(mem_be), .mem_wdata_o(mem_wdata),
    .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } acc_t;

  acc_t       exp_q[$];
  logic [7:0] mem_model [logic [31:0]];
  int n_checks = 0;
  int n_errors = 0;
  int gnt_min = 0, gnt_max = 0, rv_min = 0, rv_max = 0;

  task automatic check(input string tag, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  function automatic logic [31:0] rd_word(input logic [31:0] w);
    return {rd_byte(w + 3), rd_byte(w + 2), rd_byte(w + 1), rd_byte(w)};
  endfunction

  task automatic wr_word(input logic [31:0] w, input logic [3:0] be, input logic [31:0] d);
    for (int l = 0; l < 4; l++)
      if (be[l]) mem_model[w + l] = d[8*l +: 8];
  endtask

  // Memory responder: checks every REQ cycle against the expected access,
  // grants after a random delay, returns read data after a random delay and
  // sprinkles stray grants/rvalids where the LSU must ignore them.
  initial begin : responder
    bit          in_req, pend, was_pend;
    int          gwait, rwait;
    logic [31:0] raddr;
    acc_t        cur;
    in_req = 0; pend = 0; gwait = 0; rwait = 0; raddr = '0;
    a_gnt = 1'b0; a_rvalid = 1'b0; a_rdata = '0;
    forever begin
      @(negedge clk);
      a_gnt = 1'b0; a_rvalid = 1'b0; a_rdata = '0;
      if (!auto_mode || !rst_n) begin
        in_req = 0; pend = 0;
        continue;
      end
      was_pend = pend;
      if (pend) begin
        if (rwait == 0) begin
          a_rvalid = 1'b1;
          a_rdata  = rd_word(raddr);
          pend     = 0;
        end else begin
          rwait--;
        end
      end
      if (mem_req) begin
        if (exp_q.size() == 0) begin
          check("unexpected_req", 1, 0);
          cur.we = mem_we; cur.addr = mem_addr; cur.be = mem_be; cur.wdata = mem_wdata;
        end else begin
          cur = exp_q[0];
        end
        check("acc_we", mem_we, cur.we);
        check("acc_addr", mem_addr, cur.addr);
        check("acc_be", mem_be, cur.be);
        if (cur.we) check("acc_wdata", mem_wdata, cur.wdata);
        if (!in_req) begin
          in_req = 1;
          gwait  = $urandom_range(gnt_max, gnt_min);
        end
        if (gwait == 0) begin
          a_gnt  = 1'b1;
          in_req = 0;
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          if (cur.we) begin
            wr_word(cur.addr, cur.be, cur.wdata);
          end else begin
            pend  = 1;
            raddr = cur.addr;
            rwait = $urandom_range(rv_max, rv_min);
          end
        end else begin
          gwait--;
        end
      end else begin
        check("mem_idle", {mem_we, mem_addr, mem_be, mem_wdata}, 0);
        if (!was_pend && !pend && $urandom_range(3, 0) == 0) a_gnt = 1'b1;
        if (!was_pend && !pend && $urandom_range(3, 0) == 0) begin
          a_rvalid = 1'b1;
          a_rdata  = $urandom;
        end
      end
    end
  end

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  endtask

  // Issue one request from a negedge with the LSU idle; returns at the
  // negedge after the response, with the LSU idle again.
  task automatic do_req(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int exp_lat);
    acc_t        acc[2];
    int          na, n, lat, idx;
    bit          legal;
    logic [31:0] w, raw, exp_rd;
    n     = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    exp_rd = '0;
    na = 0;
    if (legal) begin
      for (int i = 0; i < n; i++) begin
        w = (a + i) & 32'hFFFF_FFFC;
        if (i == 0 || w != acc[na-1].addr) begin
          acc[na].we = st; acc[na].addr = w; acc[na].be = 4'b0; acc[na].wdata = '0;
          na++;
        end
        acc[na-1].be[(a + i) & 3] = 1'b1;
      end
      for (int k = 0; k < na; k++)
        for (int l = 0; l < 4; l++) begin
          idx = 4*k + l - int'(a[1:0]);
          if (idx >= 0 && idx < 4) acc[k].wdata[8*l +: 8] = wd[8*idx +: 8];
        end
      for (int k = 0; k < na; k++) exp_q.push_back(acc[k]);
      if (!st) begin
        raw = '0;
        for (int i = 0; i < n; i++) raw[8*i +: 8] = rd_byte(a + i);
        case (f3)
          3'd0:    exp_rd = {{24{raw[7]}}, raw[7:0]};
          3'd1:    exp_rd = {{16{raw[15]}}, raw[15:0]};
          default: exp_rd = raw;
        endcase
      end
    end
    check("ready_before", req_ready, 1);
    req_valid = 1'b1; req_is_store = st; req_func3 = f3; req_addr = a; req_wdata = wd;
    #1 check("stall_on_accept", stall, 1);
    @(negedge clk);
    req_valid = 1'b0; req_is_store = $urandom_range(1, 0);
    req_func3 = $urandom_range(7, 0); req_addr = $urandom; req_wdata = $urandom;
    lat = 1;
    while (!rsp_valid && lat < 200) begin
      check("stall_busy", stall, 1);
      check("ready_busy", req_ready, 0);
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) begin
      check("rsp_timeout", 0, 1);
      finish_run();
    end
    check("stall_in_resp", stall, 0);
    check("ready_in_resp", req_ready, 0);
    check("rsp_err", rsp_err, !legal);
    check("rsp_rdata", rsp_rdata, exp_rd);
    check("acc_count_left", exp_q.size(), 0);
    if (exp_lat >= 0) check("latency", lat, exp_lat);
    @(negedge clk);
    check("rsp_one_cycle", rsp_valid, 0);
    check("ready_after", req_ready, 1);
  endtask

  initial begin : main
    bit          st;
    logic [2:0]  f3;
    logic [31:0] a, base;
    rst_n = 1'b0; auto_mode = 1'b1;
    req_valid = 1'b0; req_is_store = 1'b0; req_func3 = '0; req_addr = '0; req_wdata = '0;
    m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", req_ready, 1);
    check("rst_outs", {rsp_valid, rsp_rdata, rsp_err, stall, mem_req, mem_we,
                       mem_addr, mem_be, mem_wdata}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    wr_word(32'h100, 4'hF, 32'hDDCC_BBAA);
    wr_word(32'h104, 4'hF, 32'h4433_2211);

    // Directed scenarios, immediate grant and rvalid one cycle later
    do_req(0, 3'd2, 32'h100, 32'h0, 3);                   // LW aligned
    do_req(0, 3'd0, 32'h103, 32'h0, 3);                   // LB  -> FFFFFFDD
    do_req(0, 3'd4, 32'h103, 32'h0, 3);                   // LBU -> 000000DD
    do_req(0, 3'd2, 32'h102, 32'h0, 5);                   // split LW
    do_req(1, 3'd2, 32'h200, 32'h1234_5678, 2);           // aligned SW
    gnt_min = 2; gnt_max = 2;
    do_req(1, 3'd1, 32'h107, 32'h0000_BEEF, 7);           // split SH, slow gnt
    gnt_min = 0; gnt_max = 0;
    do_req(0, 3'd3, 32'h100, 32'h0, 1);                   // illegal load
    do_req(1, 3'd5, 32'h100, 32'h0, 1);                   // illegal store
    do_req(0, 3'd2, 32'hFFFF_FFFE, 32'h0, 5);             // address wrap

    // Reset while REQ0 is waiting for a grant
    auto_mode = 1'b0;
    req_valid = 1'b1; req_is_store = 1'b0; req_func3 = 3'd2; req_addr = 32'h100;
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_req0_before", mem_req, 1);
    rst_n = 1'b0;
    #1;
    check("rst_req0_memreq", mem_req, 0);
    check("rst_req0_ready", req_ready, 1);
    check("rst_req0_stall", stall, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset during WAIT0 of a split LW, then a stray rvalid
    req_valid = 1'b1; req_is_store = 1'b0; req_func3 = 3'd2; req_addr = 32'h102;
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_w0_req", mem_req, 1);
    m_gnt = 1'b1;
    @(negedge clk);
    m_gnt = 1'b0;
    check("rst_w0_stall_before", stall, 1);
    rst_n = 1'b0;
    #1;
    check("rst_w0_memreq", mem_req, 0);
    check("rst_w0_stall", stall, 0);
    check("rst_w0_ready", req_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    m_rvalid = 1'b1; m_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    m_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rst_w0_no_rsp", {rsp_valid, mem_req, req_ready}, 3'b001);
      @(negedge clk);
    end
    exp_q.delete();
    auto_mode = 1'b1;
    do_req(0, 3'd2, 32'h100, 32'h0, 3);

    // Randomized traffic
    for (int it = 0; it < 200; it++) begin
      st = $urandom_range(1, 0);
      if ($urandom_range(9, 0) == 0) f3 = 3'($urandom_range(7, 0));
      else if (st) f3 = 3'($urandom_range(2, 0));
      else begin
        f3 = 3'($urandom_range(4, 0));
        if (f3 == 3'd3) f3 = 3'd5;
      end
      case ($urandom_range(3, 0))
        0:       base = 32'h0000_0100;
        1:       base = 32'h0000_1000;
        2:       base = 32'hFFFF_FFF0;
        default: base = $urandom & 32'hFFFF_FFF0;
      endcase
      a = base + 32'($urandom_range(15, 0));
      gnt_min = 0; gnt_max = $urandom_range(3, 0);
      rv_min  = 0; rv_max  = $urandom_range(3, 0);
      do_req(st, f3, a, $urandom, -1);
      repeat ($urandom_range(2, 0)) @(negedge clk);
    end

    finish_run();
  end

endmodule
`default_nettype wire

// File: doc/lsu_mem_req.md
Name: lsu_mem_req

Overview:
- Pipeline-side load/store initiator; the requesting end of the data-memory load/store interface.
- Accepts one load or store from the MEM stage, encoded with RV32I func3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- Converts it into word-aligned, byte-enabled memory transactions using a req/gnt/rvalid handshake.
- Splits misaligned accesses into two word accesses, merges and sign/zero-extends load data, and holds the pipeline stalled until done.

Parameters:
- ADDR_W, 32, byte-address width on both pipeline and memory sides.
- DATA_W, 32, data width; fixed at 32, and any other value is an elaboration error.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  pipeline access request.
- req_ready  out  1  LSU can accept a request (IDLE only).
- req_is_store  in  1  1 = store, 0 = load.
- req_func3  in  3  RV32I load/store func3.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, low-aligned.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  illegal func3; qualified by rsp_valid.
- stall  out  1  high from acceptance through the cycle before rsp_valid.
- mem_req  out  1  memory access request.
- mem_we  out  1  write access.
- mem_addr  out  ADDR_W  word address, bits [1:0] = 0.
- mem_be  out  4  byte enables; lane i = bits 8i+7:8i, little-endian.
- mem_wdata  out  32  lane-positioned write data.
- mem_gnt  in  1  memory accepted the access this cycle.
- mem_rvalid  in  1  read data valid; at least 1 cycle after gnt.
- mem_rdata  in  32  read word.

Behaviour:
- Reset (async, rst_n=0) clears all outputs to 0 except req_ready=1 and puts the FSM in IDLE.
- Reset mid-operation abandons the access: no rsp_valid, and mem_req drops immediately.
- Handshake: a request is accepted when req_valid&&req_ready. On acceptance the block latches is_store, func3, addr and wdata, and stall rises in the same cycle.
- Size mask: B=4'b0001, H=4'b0011, W=4'b1111. off=addr[1:0]; ext = {4'b0, mask} << off.
- Split rule: a second access is needed iff ext[7:4] != 0 (LH/SH with off=3; LW/SW with off!=0).
- Access 0: word addr = addr & ~3, be = ext[3:0].
- Access 1: word addr = (addr & ~3) + 4, be = ext[7:4]. Address wrap at 2^ADDR_W is modulo.
- Store data: ext_wdata = {32'b0, wdata} << (8*off). Access 0 drives ext_wdata[31:0]; access 1 drives ext_wdata[63:32].
- Load merge: word0 = first rdata, word1 = second rdata (0 if no split). raw = ({word1, word0} >> 8*off)[31:0].
- Load extension: LB sign-extends raw[7:0], LBU zero-extends; LH sign-extends raw[15:0], LHU zero-extends; LW passes raw.
- Illegal func3: loads 3, 6, 7; stores 3–7. No memory access; go straight to RESP with rsp_err=1 and rsp_rdata=0.
- FSM states: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
  - IDLE → REQ0 on accept, or → RESP if illegal.
  - REQ0: mem_req=1 with access-0 signals held stable until mem_gnt.
    - On gnt, a store goes to REQ1 if split, else RESP.
    - On gnt, a load goes to WAIT0.
  - WAIT0: on mem_rvalid, capture word0 → REQ1 if split, else RESP.
  - REQ1 and WAIT1 mirror REQ0 and WAIT0 for access 1; WAIT1 → RESP on mem_rvalid.
  - RESP: rsp_valid=1 for exactly one cycle, stall=0 → IDLE. req_ready stays 0 in RESP, so a new request is accepted the following cycle at the earliest.
- mem_rvalid is ignored outside WAIT0/WAIT1; mem_gnt is ignored outside REQ0/REQ1.
- Minimum latency, aligned load with immediate gnt and rvalid one cycle later: accept at cycle 0, REQ0 at cycle 1, rvalid at cycle 2, rsp_valid at cycle 3.
- Aligned store with immediate gnt: rsp_valid at cycle 2.
- Outputs mem_* are 0 in every state except REQ0/REQ1.

Decomposition:
- Shared package (the existing rv_dec header/package) holds the func3 load/store enums (LB..LHU, SB..SW), the lsu_state_e enum, and a size-mask function.
- One sub-module, lsu_align: combinational lane shifting, byte-enable generation, load merge and extension. It is instantiated once; the FSM stays in lsu_mem_req.

Test Plan:
1. Aligned LW at 0x100, mem word 0x100 = 0xDDCCBBAA, gnt immediate, rvalid +1 → one access, be=1111, rsp_rdata=0xDDCCBBAA at cycle 3.
2. LB at 0x103, then LBU at 0x103 (byte 0xDD) → rsp_rdata 0xFFFFFFDD, then 0x000000DD. Single access each, be=1000.
3. Misaligned LW at 0x102, words 0x100 = 0xDDCCBBAA and 0x104 = 0x44332211 → accesses 0x100/be 1100 then 0x104/be 0011; rsp_rdata=0x2211DDCC.
4. SH at 0x107, wdata 0x0000BEEF, gnt delayed 2 cycles each → 0x104/be 1000/wdata 0xEF000000, then 0x108/be 0001/wdata 0x000000BE. Request signals held stable while waiting; rsp_err=0.
5. Load with func3=3'b011 → no mem_req ever; rsp_valid one cycle after accept with rsp_err=1 and rsp_rdata=0.
6. rst_n low during WAIT0 of a split LW → mem_req=0, stall=0, req_ready=1 immediately. No rsp_valid; a later rvalid is ignored, and the next request completes normally.
